// File: rtl/ahb_multi_master_arbiter.sv
// AHB multi-master arbiter: round-robin grant, fixed bursts kept intact, parks on DEFAULT_MASTER.
// Optional bus locking is compiled in with `define AHB_ARB_LOCK_EN.
module ahb_multi_master_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int NUM_MASTER_BITS = $clog2(NUM_MASTERS),
  parameter int DEFAULT_MASTER  = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_MASTERS-1:0]     HBUSREQ,
  input  logic [NUM_MASTERS-1:0]     HLOCK,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HBURST,
  input  logic                       HREADY,
  output logic [NUM_MASTERS-1:0]     HGRANT,
  output logic [NUM_MASTER_BITS-1:0] HMASTER,
  output logic                       HMASTLOCK
);

  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [NUM_MASTER_BITS-1:0] DEF_IDX   = NUM_MASTER_BITS'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]     DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    PARK,
    OWNED,
`ifdef AHB_ARB_LOCK_EN
    BURST,
    LOCKED
`else
    BURST
`endif
  } state_t;

  state_t                     state, state_nxt;
  logic [4:0]                 beat_cnt, beat_nxt;
  logic [NUM_MASTER_BITS-1:0] rr_last, rr_win, grant_idx, nxt_idx, idx;
  logic [NUM_MASTERS-1:0]     grant_nxt;
  logic                       any_req, arb_ok, lock_req, lock_hold, lock_smp, fixed_nonseq, found;

  assign any_req      = |HBUSREQ;
  assign fixed_nonseq = (HTRANS == TR_NONSEQ) && (HBURST[2:1] != 2'b00);

`ifdef AHB_ARB_LOCK_EN
  assign lock_req = HLOCK[grant_idx] & HBUSREQ[grant_idx];
  assign lock_smp = HLOCK[grant_idx];
`else
  logic unused_lock;
  assign unused_lock = ^HLOCK;
  assign lock_req    = 1'b0;
  assign lock_smp    = 1'b0;
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (HGRANT[i]) grant_idx = NUM_MASTER_BITS'(i);
  end

  // beat_cnt holds beats still to come after the last accepted one, so
  // arbitrating on beat_nxt<=1 hands over during the penultimate beat.
  always_comb begin
    beat_nxt = beat_cnt;
    if (HTRANS == TR_NONSEQ) begin
      case (HBURST)
        3'b010, 3'b011: beat_nxt = 5'd3;
        3'b100, 3'b101: beat_nxt = 5'd7;
        3'b110, 3'b111: beat_nxt = 5'd15;
        default:        beat_nxt = 5'd0;
      endcase
    end else if (HTRANS == TR_SEQ && beat_cnt != 5'd0) begin
      beat_nxt = beat_cnt - 5'd1;
    end
  end

  assign arb_ok = (beat_nxt <= 5'd1) && !lock_hold;

  // Search from rr_last+1 wrapping round, so the current owner comes last.
  always_comb begin
    rr_win = rr_last;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = NUM_MASTER_BITS'((int'(rr_last) + k) % NUM_MASTERS);
      if (!found && HBUSREQ[idx]) begin
        rr_win = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_nxt = HGRANT;
    nxt_idx   = grant_idx;
    if (arb_ok) begin
      nxt_idx            = any_req ? rr_win : DEF_IDX;
      grant_nxt          = '0;
      grant_nxt[nxt_idx] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT    <= DEF_GRANT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      beat_cnt  <= 5'd0;
      rr_last   <= DEF_IDX;
    end else if (HREADY) begin
      HGRANT    <= grant_nxt;
      HMASTER   <= grant_idx;
      HMASTLOCK <= lock_smp;
      beat_cnt  <= beat_nxt;
      if (arb_ok) rr_last <= nxt_idx;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    state <= PARK;
    else if (HREADY) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PARK:   if (any_req) state_nxt = OWNED;
      OWNED: begin
`ifdef AHB_ARB_LOCK_EN
        if (lock_req)                 state_nxt = LOCKED;
        else
`endif
        if (fixed_nonseq)             state_nxt = BURST;
        else if (!any_req && arb_ok)  state_nxt = PARK;
      end
      BURST: begin
`ifdef AHB_ARB_LOCK_EN
        if (lock_req)                 state_nxt = LOCKED;
        else
`endif
        if (beat_nxt <= 5'd1)         state_nxt = OWNED;
      end
`ifdef AHB_ARB_LOCK_EN
      // Leaving LOCKED still holds for this transfer: one extra beat after HLOCK falls.
      LOCKED: if (!HLOCK[grant_idx])  state_nxt = OWNED;
`endif
      default:                        state_nxt = PARK;
    endcase
  end

  always_comb begin
    lock_hold = 1'b0;
`ifdef AHB_ARB_LOCK_EN
    lock_hold = (state == LOCKED) || lock_req;
`endif
  end

endmodule

// File: tb/tb_ahb_multi_master_arbiter.sv
// Scoreboard bench for ahb_multi_master_arbiter (4 masters, park on master 2).
// Expected grant/master/lock are queued per driven cycle and checked at the following negedge.
module tb_ahb_multi_master_arbiter;
  localparam int NM = 4;
  localparam int NB = 2;
  localparam int DEF = 2;
  localparam logic [1:0] IDLE = 2'd0, NSQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [NM-1:0] HBUSREQ, HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [NM-1:0] HGRANT;
  logic [NB-1:0] HMASTER;
  logic          HMASTLOCK;

  typedef struct {
    string         tag;
    logic [NM-1:0] g;
    logic [NB-1:0] m;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 HCLK = ~HCLK;

  ahb_multi_master_arbiter #(.NUM_MASTERS(NM), .NUM_MASTER_BITS(NB), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle; eg/em/el are the outputs expected after the coming edge.
  task automatic cyc(input string tag, input logic [NM-1:0] req, input logic [NM-1:0] lck,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                     input int eg, input int em, input logic el);
    exp_t e;
    HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu; HREADY = rdy;
    @(posedge HCLK); #1;
    e.tag = tag; e.g = NM'(1) << eg; e.m = NB'(em); e.l = el;
    sb.push_back(e);
  endtask

  always @(negedge HCLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_grant"},  32'(HGRANT),    32'(e.g));
      chk({e.tag, "_master"}, 32'(HMASTER),   32'(e.m));
      chk({e.tag, "_lock"},   32'(HMASTLOCK), 32'(e.l));
    end
  end

  initial begin
    HRESETn = 1'b0; HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b1;
    #12;
    chk("rst_grant", 32'(HGRANT), 32'h4);
    chk("rst_master", 32'(HMASTER), 32'd2);
    chk("rst_lock", 32'(HMASTLOCK), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cyc("idle_park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 2, 2, 1'b0);

    // all four request SINGLEs: rotation, HMASTER one cycle behind
    cyc("rr0", 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, 3, 2, 1'b0);
    cyc("rr1", 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, 0, 3, 1'b0);
    cyc("rr2", 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, 1, 0, 1'b0);
    cyc("rr3", 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, 2, 1, 1'b0);
    cyc("rr4", 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, 3, 2, 1'b0);
    cyc("rr5", 4'b1111, 4'b0000, NSQ, SINGLE, 1'b1, 0, 3, 1'b0);

    // HREADY low freezes everything while M2 requests
    for (int i = 0; i < 5; i++)
      cyc("wait", 4'b0100, 4'b0000, IDLE, SINGLE, 1'b0, 0, 3, 1'b0);
    cyc("wait_rel", 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 2, 0, 1'b0);
    cyc("wait_own", 4'b0100, 4'b0000, IDLE, SINGLE, 1'b1, 2, 2, 1'b0);

    // M3 transfer then all requests drop: park on default
    cyc("p_m3",   4'b1000, 4'b0000, NSQ, SINGLE, 1'b1, 3, 2, 1'b0);
    cyc("p_drop", 4'b0000, 4'b0000, NSQ, SINGLE, 1'b1, 2, 3, 1'b0);
    cyc("p_park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, 2, 2, 1'b0);

    // M1 INCR8 with M0 requesting, wait states on beat 3, M1 drops request mid-burst
    cyc("b_gnt", 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1, 2, 1'b0);
    cyc("b_own", 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1, 1, 1'b0);
    cyc("b1",    4'b0011, 4'b0000, NSQ, INCR8, 1'b1, 1, 1, 1'b0);
    cyc("b2",    4'b0011, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 1'b0);
    cyc("b3w1",  4'b0011, 4'b0000, SEQ, INCR8, 1'b0, 1, 1, 1'b0);
    cyc("b3w2",  4'b0011, 4'b0000, SEQ, INCR8, 1'b0, 1, 1, 1'b0);
    cyc("b3",    4'b0011, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 1'b0);
    cyc("b4",    4'b0011, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 1'b0);
    cyc("b5",    4'b0001, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 1'b0);
    cyc("b6",    4'b0001, 4'b0000, SEQ, INCR8, 1'b1, 1, 1, 1'b0);
    cyc("b7",    4'b0001, 4'b0000, SEQ, INCR8, 1'b1, 0, 1, 1'b0);
    cyc("b8",    4'b0001, 4'b0000, SEQ, INCR8, 1'b1, 0, 0, 1'b0);
    cyc("b_m0",  4'b0001, 4'b0000, NSQ, SINGLE, 1'b1, 0, 0, 1'b0);

    // M1 locked SINGLEs while M0 requests
    cyc("l_gnt", 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1, 0, 1'b0);
    cyc("l_own", 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1, 1, 1'b0);
`ifdef AHB_ARB_LOCK_EN
    cyc("l1", 4'b0011, 4'b0010, NSQ, SINGLE, 1'b1, 1, 1, 1'b1);
    cyc("l2", 4'b0011, 4'b0010, NSQ, SINGLE, 1'b1, 1, 1, 1'b1);
    cyc("l3", 4'b0011, 4'b0010, NSQ, SINGLE, 1'b1, 1, 1, 1'b1);
    cyc("l4", 4'b0001, 4'b0000, NSQ, SINGLE, 1'b1, 1, 1, 1'b0);
    cyc("l5", 4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 0, 1, 1'b0);
    cyc("l6", 4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 0, 0, 1'b0);
`else
    cyc("l1", 4'b0011, 4'b0010, NSQ, SINGLE, 1'b1, 0, 1, 1'b0);
    cyc("l2", 4'b0011, 4'b0010, NSQ, SINGLE, 1'b1, 1, 0, 1'b0);
    cyc("l3", 4'b0011, 4'b0010, NSQ, SINGLE, 1'b1, 0, 1, 1'b0);
    cyc("l4", 4'b0001, 4'b0000, NSQ, SINGLE, 1'b1, 0, 0, 1'b0);
    cyc("l5", 4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 0, 0, 1'b0);
    cyc("l6", 4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, 0, 0, 1'b0);
`endif

    // reset in the middle of an M0 INCR4; the burst must be forgotten
    cyc("r_b1", 4'b0011, 4'b0000, NSQ, INCR4, 1'b1, 0, 0, 1'b0);
    cyc("r_b2", 4'b0011, 4'b0000, SEQ, INCR4, 1'b1, 0, 0, 1'b0);
    @(negedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    chk("arst_grant", 32'(HGRANT), 32'h4);
    chk("arst_master", 32'(HMASTER), 32'd2);
    chk("arst_lock", 32'(HMASTLOCK), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    cyc("r_new", 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1, 2, 1'b0);
    cyc("r_own", 4'b0010, 4'b0000, IDLE, SINGLE, 1'b1, 1, 1, 1'b0);

    @(negedge HCLK); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
